uart_fifo_ctrl: RTL and testbench
=================================

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: base of the 4-word register window.
REQ-002 SHALL have parameter DATA_W, default 8: character width, legal range 5..8.
REQ-003 SHALL have parameter DEPTH, default 16: entries per FIFO, power of 2, range 2..128; AW = log2(DEPTH); counts are AW+1 bits wide.
REQ-004 SHALL have ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_wb_valid  input  1  bus request.
- i_wb_adr  input  32  byte address.
- i_wb_we  input  1  write enable.
- i_wb_dat  input  32  write data.
- i_wb_sel  input  4  byte enables.
- o_wb_ack  output  1  access acknowledge.
- o_wb_dat  output  32  read data.
- i_rx_data  input  DATA_W  received character.
- i_rx_valid  input  1  one-cycle character strobe.
- i_frame_err  input  1  framing error, qualified by i_rx_valid.
- o_tx_data  output  DATA_W  character to the serializer.
- o_tx_start  output  1  serializer start request.
- i_tx_busy  input  1  serializer busy.
- o_irq  output  1  interrupt, level, registered.

Function
REQ-005 Register map, offsets from BASE_ADDR:
- 0x0: RX_DATA, read-only.
- 0x4: TX_DATA, write-only.
- 0x8: STAT, read-only.
- 0xC: CTRL, read/write.
REQ-006 Ack timing: o_wb_ack = registered (i_wb_valid & ~o_wb_ack), giving one single-cycle ack per access, one cycle after valid; all side effects occur on the ack cycle.
REQ-007 Read data: o_wb_dat is registered with the ack; unmapped addresses ack, read 0, and ignore writes.
REQ-008 RX_DATA read: returns the RX FIFO head zero-extended and pops it; if the FIFO is empty it returns 0 with no pop.
REQ-009 TX_DATA write: requires i_wb_sel[0]; pushes i_wb_dat[DATA_W-1:0]; if the FIFO is full the data is dropped and sticky tx_ovf is set.
REQ-010 RX push: i_rx_valid & ~i_frame_err pushes i_rx_data. If the FIFO is full (and no pop in the same cycle) the data is dropped and sticky rx_ovr is set. i_rx_valid & i_frame_err discards the data and sets sticky ferr.
REQ-011 Simultaneous push and pop on one FIFO: both occur and the count is unchanged; a push while full is accepted if a pop occurs in the same cycle; pointers wrap modulo DEPTH.
REQ-012 STAT bits:
- [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full.
- [4] rx_ovr, [5] ferr, [6] tx_ovf.
- [7] tx_active (FSM not IDLE).
- [15:8] rx_count, [23:16] tx_count, zero-extended.
- Other bits read 0.
REQ-013 STAT read clears [6:4] on the ack cycle; an error event in the same cycle wins and the bit stays set.
REQ-014 CTRL bits, written per i_wb_sel byte:
- [0] rx_irq_en, [1] err_irq_en, [2] txe_irq_en.
- [15:8] rx_thresh; a written value of 0 is stored as 1.
REQ-015 o_irq is registered: (rx_irq_en & rx_count>=rx_thresh) | (err_irq_en & |STAT[6:4]) | (txe_irq_en & tx_empty & ~tx_active).
REQ-016 TX FSM, states IDLE, LOAD, START, DRAIN:
- IDLE->LOAD when TX FIFO non-empty & ~i_tx_busy; pops the head into o_tx_data.
- LOAD->START.
- START holds o_tx_start=1 until i_tx_busy=1, then goes to DRAIN.
- DRAIN->IDLE when i_tx_busy=0.
REQ-017 o_tx_data is stable from LOAD until the next LOAD; o_tx_start is 1 only in START.

Reset
REQ-018 On rst_n low, immediately:
- Both FIFOs emptied (pointers and counts 0).
- Sticky bits 0, CTRL 0, rx_thresh 1.
- FSM IDLE.
- o_wb_ack, o_wb_dat, o_tx_data, o_tx_start, o_irq all 0.
REQ-019 Reset mid-transfer abandons the character in flight; after release, STAT reads 0x0000_0005.

Configuration
REQ-020 Macro UART_FIFO_IRQ_EN:
- Defined: REQ-014 and REQ-015 are implemented.
- Undefined: CTRL reads 0, writes to it are ignored, o_irq is tied 0, and no interrupt logic is generated.

Verification
REQ-021 Write 0x41, 0x42 to TX_DATA with the serializer busy for 10 cycles per character -> o_tx_data=0x41 then 0x42, two o_tx_start episodes, then STAT[2]=1 and STAT[7]=0.
REQ-022 Push DEPTH+1 RX characters with no reads -> STAT[1]=1, STAT[4]=1, rx_count=DEPTH; then DEPTH RX_DATA reads return the data in order; the next read returns 0.
REQ-023 i_rx_valid with i_frame_err=1 and data 0x55 -> no push, STAT[5]=1; a STAT read returns bit5=1; the next STAT read returns bit5=0.
REQ-024 With RX FIFO full, i_rx_valid coincides with the RX_DATA pop ack -> rx_count stays DEPTH and rx_ovr stays 0.
REQ-025 With IRQ_EN defined, CTRL=0x0000_0301: o_irq rises the cycle after the 3rd RX push and falls after the first pop; with the macro undefined, o_irq stays 0.
REQ-026 Assert rst_n low during START -> o_tx_start=0 immediately, STAT=0x0000_0005 after release.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: register-mapped UART buffer controller.
// Holds an RX FIFO fed by the deserializer and a TX FIFO drained by a small
// FSM into the serializer, behind a 4-word bus window (RX_DATA, TX_DATA,
// STAT, CTRL).
// Build option: define UART_FIFO_IRQ_EN to get the CTRL register and the
// o_irq logic; without it CTRL reads 0 and o_irq is tied low.
//
// Bus handshake: a request is taken on any clock edge where i_wb_valid is
// high and o_wb_ack is low. That same edge commits every side effect (FIFO
// push/pop, sticky clear, CTRL write) and registers o_wb_ack=1 together with
// o_wb_dat, so the master sees exactly one single-cycle ack per access.
`timescale 1ns/1ps

module uart_fifo_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_valid,
  input  logic [31:0]       i_wb_adr,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_dat,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_frame_err,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic              o_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_DRAIN = 2'd3
  } tx_state_e;

  // Bus decode
  logic        ack_q;
  logic [31:0] dat_q;
  logic        acc;
  logic        hit;
  logic [1:0]  idx;
  logic        rd_rx, wr_tx, rd_stat, wr_ctrl;

  assign acc     = i_wb_valid & ~ack_q;
  assign hit     = (i_wb_adr[31:4] == BASE_ADDR[31:4]) && (i_wb_adr[1:0] == 2'b00);
  assign idx     = i_wb_adr[3:2];
  assign rd_rx   = acc & ~i_wb_we & hit & (idx == 2'd0);
  assign wr_tx   = acc &  i_wb_we & hit & (idx == 2'd1) & i_wb_sel[0];
  assign rd_stat = acc & ~i_wb_we & hit & (idx == 2'd2);
  assign wr_ctrl = acc &  i_wb_we & hit & (idx == 2'd3);

  // RX FIFO state
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     rx_wr_q, rx_rd_q;
  logic [CW-1:0]     rx_cnt_q;
  logic              rx_empty, rx_full, rx_pop, rx_push;

  // TX FIFO state
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW-1:0]     tx_wr_q, tx_rd_q;
  logic [CW-1:0]     tx_cnt_q;
  logic              tx_empty, tx_full, tx_pop, tx_push;

  // TX FSM
  tx_state_e         state_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              tx_active;

  // Sticky error flags
  logic rx_ovr_q, ferr_q, tx_ovf_q;
  logic rx_ovr_set, ferr_set, tx_ovf_set;

  logic [31:0] stat;
  logic [31:0] ctrl_rd;
  logic [31:0] rdata;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(DEPTH));

  // A push into a full FIFO is still taken when a pop frees a slot this cycle.
  assign rx_pop  = rd_rx & ~rx_empty;
  assign rx_push = i_rx_valid & ~i_frame_err & (~rx_full | rx_pop);
  assign tx_pop  = (state_q == S_IDLE) & ~tx_empty & ~i_tx_busy;
  assign tx_push = wr_tx & (~tx_full | tx_pop);

  assign rx_ovr_set = i_rx_valid & ~i_frame_err & rx_full & ~rx_pop;
  assign ferr_set   = i_rx_valid & i_frame_err;
  assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

  assign tx_active = (state_q != S_IDLE);

  // RX FIFO storage write port
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= i_rx_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
    end
  end

  // TX FIFO storage write port
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= i_wb_dat[DATA_W-1:0];
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
    end
  end

  // Sticky errors: a STAT read clears them, a same-cycle event keeps them set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovr_q <= 1'b0;
      ferr_q   <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_ovr_q <= (rx_ovr_q & ~rd_stat) | rx_ovr_set;
      ferr_q   <= (ferr_q   & ~rd_stat) | ferr_set;
      tx_ovf_q <= (tx_ovf_q & ~rd_stat) | tx_ovf_set;
    end
  end

  // TX FSM: hand one character at a time to the serializer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_pop) begin
            state_q   <= S_LOAD;
            tx_data_q <= tx_mem[tx_rd_q];
          end
        end
        S_LOAD: begin
          state_q    <= S_START;
          tx_start_q <= 1'b1;
        end
        S_START: begin
          if (i_tx_busy) begin
            state_q    <= S_DRAIN;
            tx_start_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!i_tx_busy) state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  // STAT word assembled from live status
  always_comb begin
    stat          = '0;
    stat[0]       = rx_empty;
    stat[1]       = rx_full;
    stat[2]       = tx_empty;
    stat[3]       = tx_full;
    stat[4]       = rx_ovr_q;
    stat[5]       = ferr_q;
    stat[6]       = tx_ovf_q;
    stat[7]       = tx_active;
    stat[8 +: CW]  = rx_cnt_q;
    stat[16 +: CW] = tx_cnt_q;
  end

`ifdef UART_FIFO_IRQ_EN
  logic [2:0] irq_en_q;
  logic [7:0] thresh_q;
  logic       irq_q;
  logic       irq_d;
  logic       unused_bus;

  assign unused_bus = ^{i_wb_dat[31:16], i_wb_dat[7:3], i_wb_sel[3:2]};

  // CTRL register, byte-lane writes; a zero threshold is stored as 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= '0;
      thresh_q <= 8'd1;
    end else if (wr_ctrl) begin
      if (i_wb_sel[0]) irq_en_q <= i_wb_dat[2:0];
      if (i_wb_sel[1]) thresh_q <= (i_wb_dat[15:8] == 8'd0) ? 8'd1 : i_wb_dat[15:8];
    end
  end

  assign ctrl_rd = {16'd0, thresh_q, 5'd0, irq_en_q};
  assign irq_d   = (irq_en_q[0] & (stat[15:8] >= thresh_q)) |
                   (irq_en_q[1] & (|stat[6:4])) |
                   (irq_en_q[2] & tx_empty & ~tx_active);

  // Registered interrupt level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign o_irq = irq_q;
`else
  logic unused_bus;

  assign unused_bus = ^{i_wb_dat[31:DATA_W], i_wb_sel[3:1], wr_ctrl};
  assign ctrl_rd    = '0;
  assign o_irq      = 1'b0;
`endif

  // Read mux; unmapped and write-only locations read 0
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (idx)
        2'd0: if (!rx_empty) rdata[DATA_W-1:0] = rx_mem[rx_rd_q];
        2'd2: rdata = stat;
        2'd3: rdata = ctrl_rd;
        default: rdata = '0;
      endcase
    end
  end

  // Ack and read data registered together, one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !i_wb_we) ? rdata : 32'd0;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_dat   = dat_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl with default parameters (DEPTH=16,
// DATA_W=8). A small serializer model answers o_tx_start; RX data is
// tracked through an expected queue.
`timescale 1ns/1ps

module tb_uart_fifo_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_RX   = BASE + 32'h0;
  localparam logic [31:0] A_TX   = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;
  localparam int DEPTH = 16;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_wb_valid = 1'b0;
  logic [31:0] i_wb_adr = '0;
  logic        i_wb_we = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        i_frame_err = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_busy;
  logic        o_irq;

  logic ser_busy = 1'b0;
  logic hold_busy = 1'b0;
  logic ser_en = 1'b0;
  assign i_tx_busy = ser_busy | hold_busy;

  uart_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wb_valid (i_wb_valid),
    .i_wb_adr   (i_wb_adr),
    .i_wb_we    (i_wb_we),
    .i_wb_dat   (i_wb_dat),
    .i_wb_sel   (i_wb_sel),
    .o_wb_ack   (o_wb_ack),
    .o_wb_dat   (o_wb_dat),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .i_frame_err(i_frame_err),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy),
    .o_irq      (o_irq)
  );

  // Scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int starts = 0;
  logic prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Serializer model: accept a start, stay busy 10 cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ser_en && o_tx_start && !i_tx_busy) begin
        cap_q.push_back(o_tx_data);
        ser_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 ser_busy = 1'b0;
      end
    end
  end

  // Count o_tx_start episodes
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start && !prev_start) starts++;
      prev_start = o_tx_start;
    end
  end

  // Driver tasks
  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic rx_co, input logic [7:0] rx_d,
                    output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    while (o_wb_ack) @(negedge clk);
    i_wb_valid = 1'b1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
    if (rx_co) begin
      i_rx_data = rx_d; i_rx_valid = 1'b1; i_frame_err = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      i_rx_valid = 1'b0;
      if (o_wb_ack) begin
        got = 1'b1;
        rd  = o_wb_dat;
        break;
      end
    end
    i_wb_valid = 1'b0; i_wb_we = 1'b0;
    check("wb_ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
    wb(1'b0, adr, 32'd0, 4'hF, 1'b0, 8'd0, rd);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb(1'b1, adr, dat, sel, 1'b0, 8'd0, dummy);
  endtask

  task automatic rx_push(input logic [7:0] d, input logic ferr);
    @(negedge clk);
    i_rx_data = d; i_frame_err = ferr; i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0; i_frame_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_stat(input string tag, input logic [31:0] exp);
    logic [31:0] rd;
    wb_rd(A_STAT, rd);
    check(tag, rd, exp);
  endtask

  task automatic drain_rx(input string tag);
    logic [31:0] rd;
    logic [7:0]  e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wb_rd(A_RX, rd);
      check(tag, rd, {24'd0, e});
    end
  endtask

  initial begin
    logic [31:0] rd;
    int base_starts;
    logic seen;

    // Reset state, checked while rst_n is low
    #2;
    check("reset_outputs", {o_wb_ack, o_tx_start, o_irq, o_tx_data, 5'd0}, 32'd0);
    check("reset_wb_dat", o_wb_dat, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_stat("stat_after_reset", 32'h0000_0005);

    // Unmapped and write-only locations
    wb_rd(BASE + 32'h10, rd);
    check("unmapped_read", rd, 32'd0);
    wb_wr(BASE + 32'h10, 32'h0000_00AA, 4'hF);
    wb_rd(A_TX, rd);
    check("tx_data_reads_zero", rd, 32'd0);
    read_stat("stat_after_unmapped_write", 32'h0000_0005);

    // RX overrun: DEPTH+1 pushes, then in-order drain and an empty read
    for (int i = 0; i <= DEPTH; i++) begin
      rx_push(8'h10 + 8'(i), 1'b0);
      if (i < DEPTH) exp_q.push_back(8'h10 + 8'(i));
    end
    read_stat("stat_rx_full_ovr", 32'h0000_1016);
    drain_rx("rx_data_order");
    wb_rd(A_RX, rd);
    check("rx_empty_read", rd, 32'd0);
    read_stat("stat_rx_drained", 32'h0000_0005);

    // Framing error
    rx_push(8'h55, 1'b1);
    read_stat("stat_ferr_set", 32'h0000_0025);
    read_stat("stat_ferr_cleared", 32'h0000_0005);

    // Push coincident with pop while full
    for (int i = 0; i < DEPTH; i++) begin
      rx_push(8'h80 + 8'(i), 1'b0);
      exp_q.push_back(8'h80 + 8'(i));
    end
    wb(1'b0, A_RX, 32'd0, 4'hF, 1'b1, 8'hAA, rd);
    check("rx_pop_with_push", rd, {24'd0, exp_q.pop_front()});
    exp_q.push_back(8'hAA);
    read_stat("stat_full_no_ovr", 32'h0000_1006);
    drain_rx("rx_wrap_order");
    read_stat("stat_rx_drained2", 32'h0000_0005);

    // CTRL register and interrupt
    wb_wr(A_CTRL, 32'h0000_0000, 4'hF);
    wb_rd(A_CTRL, rd);
`ifdef UART_FIFO_IRQ_EN
    check("ctrl_thresh_zero_is_one", rd, 32'h0000_0100);
`else
    check("ctrl_thresh_zero_is_one", rd, 32'h0000_0000);
`endif
    wb_wr(A_CTRL, 32'h0000_0301, 4'hF);
    wb_rd(A_CTRL, rd);
`ifdef UART_FIFO_IRQ_EN
    check("ctrl_readback", rd, 32'h0000_0301);
`else
    check("ctrl_readback", rd, 32'h0000_0000);
`endif
    rx_push(8'h01, 1'b0);
    rx_push(8'h02, 1'b0);
    repeat (2) @(negedge clk);
    check("irq_below_thresh", {31'd0, o_irq}, 32'd0);
    rx_push(8'h03, 1'b0);
    @(negedge clk);
`ifdef UART_FIFO_IRQ_EN
    check("irq_at_thresh", {31'd0, o_irq}, 32'd1);
`else
    check("irq_at_thresh", {31'd0, o_irq}, 32'd0);
`endif
    wb_rd(A_RX, rd);
    check("irq_pop_data", rd, 32'h0000_0001);
    repeat (2) @(negedge clk);
    check("irq_after_pop", {31'd0, o_irq}, 32'd0);
    do_reset();
    read_stat("stat_after_irq_reset", 32'h0000_0005);

    // Two characters through the serializer
    ser_en = 1'b1;
    base_starts = starts;
    wb_wr(A_TX, 32'h0000_0041, 4'h1);
    wb_wr(A_TX, 32'h0000_0042, 4'h1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((starts - base_starts) == 2 && !i_tx_busy) break;
    end
    repeat (4) @(negedge clk);
    check("tx_start_episodes", starts - base_starts, 32'd2);
    check("tx_capture_count", cap_q.size(), 32'd2);
    if (cap_q.size() >= 2) begin
      check("tx_char0", {24'd0, cap_q[0]}, 32'h0000_0041);
      check("tx_char1", {24'd0, cap_q[1]}, 32'h0000_0042);
    end
    read_stat("stat_tx_done", 32'h0000_0005);
    ser_en = 1'b0;

    // TX overflow with the serializer held busy; sel[0] gating
    hold_busy = 1'b1;
    wb_wr(A_TX, 32'h0000_0077, 4'hE);
    read_stat("stat_tx_no_sel0", 32'h0000_0005);
    for (int i = 0; i <= DEPTH; i++) wb_wr(A_TX, 32'h0000_0060 + i, 4'h1);
    read_stat("stat_tx_full_ovf", 32'h0010_0049);
    read_stat("stat_tx_ovf_cleared", 32'h0010_0009);
    do_reset();
    hold_busy = 1'b0;
    read_stat("stat_after_tx_reset", 32'h0000_0005);

    // Reset during START
    wb_wr(A_TX, 32'h0000_0033, 4'h1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("tx_start_reached", {31'd0, seen}, 32'd1);
    check("tx_data_in_start", {24'd0, o_tx_data}, 32'h0000_0033);
    #2 rst_n = 1'b0;
    #1;
    check("tx_start_async_clear", {31'd0, o_tx_start}, 32'd0);
    check("tx_data_async_clear", {24'd0, o_tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_stat("stat_after_start_reset", 32'h0000_0005);
    repeat (3) @(negedge clk);
    check("tx_start_stays_low", {31'd0, o_tx_start}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
